// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } arbState_e;

  // Counter width able to hold 0..maxVal, never narrower than one bit.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of data grants taken while a fetch was waiting.
module arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 2,
  parameter int CNT_W      = cntWidth(STARVE_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic incr,
  input  logic clr,
  output logic sat
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  // Clear wins over increment; the two never coincide from the arbiter anyway.
  always_ff @(posedge clk) begin
    if (rst)                         cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (incr && cnt != MAX_CNT) cnt <= cnt + 1'b1;
  end

  assign sat = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with
// data priority bounded by a starvation limit on the fetch side.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arbState_e state;
  logic      ownerData;
  logic      starveSat;
  logic      grantData;
  logic      grantFetch;

  // Data wins unless the fetch side has already been passed over STARVE_MAX times.
  always_comb begin
    grantData  = 1'b0;
    grantFetch = 1'b0;
    if (state == IDLE) begin
      grantData  = dm_req && !(if_req && starveSat);
      grantFetch = !grantData && if_req;
    end
  end

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) uStarve (
    .clk  (clk),
    .rst  (rst),
    .incr (grantData && if_req),
    .clr  (grantFetch),
    .sat  (starveSat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ownerData <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Request fields are captured here; the requester may change them afterwards.
          if (grantData) begin
            state     <= DATA;
            ownerData <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (grantFetch) begin
            state     <= FETCH;
            ownerData <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        FETCH, DATA: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if_done <= !ownerData;
            dm_done <= ownerData;
            if (!ownerData)  if_rdata <= mem_rdata;
            else if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        RESP: begin
          state   <= IDLE;
          if_done <= 1'b0;
          dm_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed vector table, corner sequences, then
// randomized traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int DW         = 32;
  localparam int STARVE_MAX = 2;

  logic          clk;
  logic          rst;
  logic          if_req, if_done, if_stall;
  logic [DW-1:0] if_addr, if_rdata;
  logic          dm_req, dm_we, dm_done, dm_stall;
  logic [DW-1:0] dm_addr, dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.DATA_W(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory model: sparse contents with a default pattern, configurable latency.
  logic [31:0] memArr [logic [31:0]];
  bit memAuto = 1'b1;
  bit memRand = 1'b0;
  int memLat  = 0;
  int curLat  = 0;
  int waitCnt = 0;
  bit memBusy = 1'b0;

  function automatic logic [31:0] rdFn(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic memCycle();
    if (!memAuto) return;
    if (mem_req === 1'b1) begin
      if (!memBusy) begin
        memBusy = 1'b1;
        waitCnt = 0;
        curLat  = memRand ? int'($urandom_range(0, 3)) : memLat;
      end
      if (waitCnt == curLat) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          memArr[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = rdFn(mem_addr);
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      waitCnt++;
    end else begin
      memBusy   = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    memCycle();
  endtask

  typedef struct {
    bit          ifReq;
    logic [31:0] ifAddr;
    bit          dmReq;
    bit          dmWe;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    int          lat;
    int          expFirst;   // 1 = fetch done first, 2 = data done first
    int          expCyc;     // cycles from request to first done
    logic [31:0] expIfRdata;
    logic [31:0] expDmRdata;
  } vec_t;

  vec_t vecs [6];

  // Random-phase model state
  int          starveM;
  bit          prevMemReq;
  bit          fPend, fGranted, dPend, dGranted, dWeR;
  int          fGap, dGap, fWait, dWait;
  logic [31:0] fAddr, dAddr, dWdataR, gAddr, gWdata, expIf, expDm, dmModel;
  bit          gWe, isData, expData;

  initial begin
    int firstKind, firstCyc, n, reqCyc, stab;
    bit seen;
    int grants[$];
    bit pm;

    memArr[32'h10] = 32'h0050_0093;
    memArr[32'h20] = 32'hCAFE_F00D;
    memArr[32'h40] = 32'h1234_5678;
    memArr[32'h44] = 32'h0BAD_F00D;

    vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,         0, 1, 2, 32'h0050_0093, 32'h0};
    vecs[1] = '{1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0,         0, 2, 2, 32'hCAFE_F00D, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 1, 2, 3, 32'hCAFE_F00D, 32'h1234_5678};
    vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h80, 32'h0,         2, 2, 4, 32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,  32'h0,         3, 1, 5, 32'h0BAD_F00D, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0,         1, 2, 3, 32'h0050_0093, 32'hCAFE_F00D};

    rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
    dm_addr = 0; dm_wdata = 0; mem_ack = 0; mem_rdata = 0;
    cyc(); cyc(); cyc();
    chk("rst_memReq", mem_req, 0);
    chk("rst_memWe", mem_we, 0);
    chk("rst_memAddr", mem_addr, 0);
    chk("rst_ifDone", if_done, 0);
    chk("rst_dmDone", dm_done, 0);
    chk("rst_ifRdata", if_rdata, 0);
    chk("rst_dmRdata", dm_rdata, 0);
    rst = 1'b0;
    cyc(); cyc();

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      memLat = vecs[v].lat; memRand = 1'b0;
      if_req = vecs[v].ifReq; if_addr = vecs[v].ifAddr;
      dm_req = vecs[v].dmReq; dm_we = vecs[v].dmWe;
      dm_addr = vecs[v].dmAddr; dm_wdata = vecs[v].dmWdata;
      firstKind = 0; firstCyc = 0; n = 0;
      while ((if_req || dm_req) && n < 40) begin
        cyc(); n++;
        if (dm_done && dm_req) begin
          if (firstKind == 0) begin firstKind = 2; firstCyc = n; end
          dm_req = 0;
        end
        if (if_done && if_req) begin
          if (firstKind == 0) begin firstKind = 1; firstCyc = n; end
          if_req = 0;
        end
      end
      chk($sformatf("vec%0d_timeout", v), {31'b0, if_req | dm_req}, 0);
      chk($sformatf("vec%0d_firstDone", v), firstKind, vecs[v].expFirst);
      chk($sformatf("vec%0d_latency", v), firstCyc, vecs[v].expCyc);
      chk($sformatf("vec%0d_ifRdata", v), if_rdata, vecs[v].expIfRdata);
      chk($sformatf("vec%0d_dmRdata", v), dm_rdata, vecs[v].expDmRdata);
      cyc(); cyc();
    end

    // Data held continuously with fetch pending: grants go D, D, F
    memLat = 0;
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    pm = 1'b0; n = 0;
    while (if_req && n < 40) begin
      cyc(); n++;
      if (mem_req && !pm) grants.push_back((mem_addr == 32'h10) ? 1 : 2);
      pm = mem_req;
      if (if_done) begin if_req = 0; dm_req = 0; end
    end
    cyc(); cyc();
    chk("starve_grantCount", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("starve_grant0", grants[0], 2);
      chk("starve_grant1", grants[1], 2);
      chk("starve_grant2", grants[2], 1);
    end

    // Store with 3-cycle ack delay; request fields change after grant
    memLat = 3;
    dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF;
    reqCyc = 0; stab = 0; seen = 0; n = 0;
    while (!seen && n < 20) begin
      cyc(); n++;
      if (mem_req) begin
        reqCyc++;
        if (mem_we && mem_addr == 32'h80 && mem_wdata == 32'hDEAD_BEEF) stab++;
        dm_addr = 32'h84; dm_wdata = 32'h0; dm_we = 0;
      end
      if (dm_done) begin seen = 1; dm_req = 0; end
    end
    chk("store_done", seen, 1);
    chk("store_reqCycles", reqCyc, 4);
    chk("store_stableCycles", stab, 4);
    chk("store_dmRdataHeld", dm_rdata, 32'h1234_5678);
    cyc(); cyc();

    // Fetch request dropped one cycle into the access still completes
    memLat = 2;
    if_req = 1; if_addr = 32'h20;
    cyc();
    if_req = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (if_done) seen = 1;
    end
    chk("drop_ifDone", seen, 1);
    chk("drop_ifRdata", if_rdata, 32'hCAFE_F00D);

    // Reset in DATA before ack, then a late ack
    memAuto = 0; mem_ack = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    cyc();
    chk("rstMid_memReqUp", mem_req, 1);
    rst = 1; dm_req = 0;
    cyc();
    chk("rstMid_memReq", mem_req, 0);
    chk("rstMid_dmDone", dm_done, 0);
    chk("rstMid_dmRdata", dm_rdata, 0);
    chk("rstMid_ifRdata", if_rdata, 0);
    rst = 0; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    cyc();
    chk("lateAck_dmDone", dm_done, 0);
    chk("lateAck_memReq", mem_req, 0);
    mem_ack = 0;
    cyc();
    chk("lateAck_dmDone2", dm_done, 0);
    chk("lateAck_dmRdata", dm_rdata, 0);
    memAuto = 1; memRand = 1;
    cyc();

    // Randomized traffic against a transaction-level model
    starveM = 0; prevMemReq = 0; dmModel = 0;
    fPend = 0; fGranted = 0; dPend = 0; dGranted = 0;
    fGap = 0; dGap = 0; fWait = 0; dWait = 0;
    for (int c = 0; c < 1500; c++) begin
      cyc();
      if (mem_req && !prevMemReq) begin
        isData  = mem_addr[29];
        expData = dm_req && !(if_req && starveM == STARVE_MAX);
        chk("rnd_grantCause", {31'b0, if_req | dm_req}, 1);
        chk("rnd_grantOwner", isData, expData);
        if (isData) begin
          if (if_req && starveM < STARVE_MAX) starveM++;
          chk("rnd_dAddr", mem_addr, dAddr);
          chk("rnd_dWe", mem_we, dWeR);
          if (dWeR) chk("rnd_dWdata", mem_wdata, dWdataR);
          dGranted = 1;
          expDm = dWeR ? dmModel : rdFn(dAddr);
          dm_wdata = $urandom; dm_addr = $urandom;
        end else begin
          starveM = 0;
          chk("rnd_fAddr", mem_addr, fAddr);
          chk("rnd_fWe", mem_we, 0);
          fGranted = 1;
          expIf = rdFn(fAddr);
          if_addr = $urandom;
        end
        gAddr = mem_addr; gWe = mem_we; gWdata = mem_wdata;
      end else if (mem_req) begin
        chk("rnd_addrStable", mem_addr, gAddr);
        chk("rnd_weStable", mem_we, gWe);
        chk("rnd_wdataStable", mem_wdata, gWdata);
      end
      chk("rnd_ifStall", if_stall, if_req & ~if_done);
      chk("rnd_dmStall", dm_stall, dm_req & ~dm_done);
      if (if_done) begin
        chk("rnd_ifDoneOwned", fGranted, 1);
        chk("rnd_ifRdata", if_rdata, expIf);
        fPend = 0; fGranted = 0; if_req = 0; fGap = $urandom_range(0, 3);
      end
      if (dm_done) begin
        chk("rnd_dmDoneOwned", dGranted, 1);
        chk("rnd_dmRdata", dm_rdata, expDm);
        dmModel = expDm;
        dPend = 0; dGranted = 0; dm_req = 0; dGap = $urandom_range(0, 3);
      end
      if (fPend) begin
        fWait++;
        if (fWait == 80) chk("rnd_fetchTimeout", 1, 0);
      end
      if (dPend) begin
        dWait++;
        if (dWait == 80) chk("rnd_dataTimeout", 1, 0);
      end
      if (c < 1400) begin
        if (!fPend) begin
          if (fGap > 0) fGap--;
          else if ($urandom_range(0, 3) != 0) begin
            fPend = 1; fWait = 0;
            fAddr = 32'h1000_0000 | (32'($urandom_range(0, 63)) << 2);
            if_req = 1; if_addr = fAddr;
          end
        end
        if (!dPend) begin
          if (dGap > 0) dGap--;
          else if ($urandom_range(0, 3) != 0) begin
            dPend = 1; dWait = 0;
            dAddr = 32'h2000_0000 | (32'($urandom_range(0, 15)) << 2);
            dWeR = $urandom_range(0, 1) == 1;
            dWdataR = $urandom;
            dm_req = 1; dm_addr = dAddr; dm_we = dWeR; dm_wdata = dWdataR;
          end
        end
      end
      prevMemReq = mem_req;
    end
    chk("rnd_drained", {30'b0, fPend, dPend}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, 32, width of address and data buses.
REQ-002 SHALL have parameter STARVE_MAX, 2, consecutive data grants allowed while fetch waits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port if_req  input  1  fetch request, held until if_done.
REQ-006 SHALL have port if_addr  input  DATA_W  fetch address.
REQ-007 SHALL have port if_done  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port if_rdata  output  DATA_W  registered fetched instruction.
REQ-009 SHALL have port if_stall  output  1  if_req & ~if_done, drives PC/IF-ID stall.
REQ-010 SHALL have port dm_req  input  1  data request, held until dm_done.
REQ-011 SHALL have port dm_we  input  1  data write enable (1 = store).
REQ-012 SHALL have port dm_addr  input  DATA_W  data address.
REQ-013 SHALL have port dm_wdata  input  DATA_W  store data.
REQ-014 SHALL have port dm_done  output  1  one-cycle data completion pulse.
REQ-015 SHALL have port dm_rdata  output  DATA_W  registered load data.
REQ-016 SHALL have port dm_stall  output  1  dm_req & ~dm_done.
REQ-017 SHALL have port mem_req  output  1  shared memory request.
REQ-018 SHALL have port mem_we  output  1  shared memory write enable.
REQ-019 SHALL have port mem_addr  output  DATA_W  shared memory address.
REQ-020 SHALL have port mem_wdata  output  DATA_W  shared memory write data.
REQ-021 SHALL have port mem_rdata  input  DATA_W  shared memory read data, valid with mem_ack.
REQ-022 SHALL have port mem_ack  input  1  memory completion, any latency >= 0 cycles after mem_req.

Function
REQ-023 SHALL implement FSM states IDLE, FETCH, DATA, RESP; no other states reachable.
REQ-024 SHALL, in IDLE, go to DATA if dm_req and not (if_req and starve_cnt == STARVE_MAX); else to FETCH if if_req; else stay IDLE.
REQ-025 SHALL latch addr/we/wdata of the granted requester on the IDLE->FETCH/DATA edge; later input changes are ignored.
REQ-026 SHALL assert mem_req exactly in FETCH and DATA, with mem_addr/mem_wdata/mem_we stable until mem_ack.
REQ-027 SHALL drive mem_we = 0 in FETCH and in every non-DATA state.
REQ-028 SHALL, on mem_ack in FETCH/DATA, capture mem_rdata (reads only) and enter RESP.
REQ-029 SHALL pulse if_done or dm_done (owner of the access) for exactly the RESP cycle, then return to IDLE without arbitrating in RESP.
REQ-030 SHALL leave dm_rdata unchanged on store completion; if_rdata/dm_rdata hold until their next read completion.
REQ-031 SHALL ignore mem_ack in IDLE and RESP.
REQ-032 SHALL complete a granted access even if its request drops mid-access, including the done pulse.
REQ-033 SHALL increment starve_cnt (saturating at STARVE_MAX) on each DATA grant with if_req high, and clear it on each FETCH grant.
REQ-034 SHALL give best-case latency: request in IDLE at cycle t, mem_req at t+1, mem_ack at t+1 gives done at t+2, IDLE at t+3.

Reset
REQ-035 SHALL, with rst high at a clock edge, set state IDLE, starve_cnt 0, if_rdata/dm_rdata 0, and latched addr/wdata/we 0.
REQ-036 SHALL hold all outputs low except the rdata registers (0) during reset.
REQ-037 SHALL, on reset mid-access, drop mem_req the cycle after and issue no done pulse for the aborted access.

Structure
REQ-038 SHALL place the state enum and the DATA_W default in a shared package used by the datapath.
REQ-039 SHALL implement the saturating starvation counter as sub-module arb_starve_cnt; the remainder is one FSM module.

Verification
REQ-040 SHALL cover: if_req only, addr 0x10, mem_ack at t+1 with 0x00500093 -> if_done at t+2, if_rdata = 0x00500093.
REQ-041 SHALL cover: if_req and dm_req together, dm load 0x40, starve_cnt 0 -> DATA granted first, dm_done before if_done.
REQ-042 SHALL cover: dm_req held with STARVE_MAX = 2 and if_req pending -> grant order DATA, DATA, FETCH.
REQ-043 SHALL cover: store 0xDEADBEEF to 0x80 with mem_ack delayed 3 cycles -> mem_we/addr/wdata stable 4 cycles, dm_rdata unchanged.
REQ-044 SHALL cover: rst asserted in DATA before mem_ack -> IDLE next cycle, mem_req 0, no dm_done, a late mem_ack ignored.
